// File: rtl/seven_seg_scan_pkg.sv
// Shared display definitions: segment patterns, idle drive levels, scan states
// and the anode-select helper used by the scan controller.
package seven_seg_scan_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  // One-hot-low anode for digit idx, or all anodes off when the digit is disabled.
  function automatic logic [7:0] an_select(input logic [2:0] idx, input logic lit);
    logic [7:0] onehot;
    onehot = 8'b0000_0001 << idx;
    return lit ? ~onehot : AN_OFF;
  endfunction

endpackage

// File: rtl/seven_seg_scan_hex_to_seg.sv
// Combinational hex digit to active-low seven-segment decoder.
module hex_to_seg
  import seven_seg_scan_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: default first so every path assigns seg and no latch is inferred.
    seg = SEG_OFF;
    case (code)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Eight-digit common-anode scan driver: walks num through the digit mux,
// decodes the returned code and lights one anode per slot with a blank gap.
module seven_seg_scan
  import seven_seg_scan_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] digit_en,
  input  logic [7:0] dp,
  input  logic [3:0] code,
  output logic [2:0] num,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp_n,
  output logic       frame_tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [6:0]    seg_dec;

  hex_to_seg u_dec (
    .code (code),
    .seg  (seg_dec)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, and all registers clear asynchronously on rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      num        <= 3'd0;
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      // Decode runs in every state; only the anodes decide what is visible.
      seg        <= seg_dec;
      dp_n       <= ~dp[num];
      frame_tick <= 1'b0;

      if (!en) begin
        state <= IDLE;
        cnt   <= '0;
        num   <= 3'd0;
        an    <= AN_OFF;
      end else begin
        case (state)
          IDLE: begin
            state <= BLANK;
            cnt   <= '0;
            an    <= AN_OFF;
          end

          BLANK: begin
            if (cnt == BLANK_LAST) begin
              state <= SHOW;
              cnt   <= '0;
              an    <= an_select(num, digit_en[num]);
            end else begin
              cnt <= cnt + CW'(1);
              an  <= AN_OFF;
            end
          end

          SHOW: begin
            if (cnt == SHOW_LAST) begin
              state      <= BLANK;
              cnt        <= '0;
              num        <= num + 3'd1;
              an         <= AN_OFF;
              frame_tick <= (num == 3'd7);
            end else begin
              // Re-evaluated each cycle so a digit_en change lands on the next edge.
              cnt <= cnt + CW'(1);
              an  <= an_select(num, digit_en[num]);
            end
          end

          default: begin
            state <= IDLE;
            cnt   <= '0;
            num   <= 3'd0;
            an    <= AN_OFF;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with SCAN_DIV=4, BLANK_CYC=2 (6-cycle digit period).
module tb_seven_seg_scan;

  localparam int SCAN_DIV  = 4;
  localparam int BLANK_CYC = 2;
  localparam int PERIOD    = SCAN_DIV + BLANK_CYC;

  // Hand-copied hex map, active-low {g..a}.
  localparam logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] digit_en;
  logic [7:0] dp;
  logic [3:0] code;
  logic [2:0] num;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp_n;
  logic       frame_tick;

  // Digit mux model: returns num unless the bench forces a fixed code.
  logic       force_en;
  logic [3:0] force_val;
  assign code = force_en ? force_val : {1'b0, num};

  int n_checks = 0;
  int n_fail   = 0;

  seven_seg_scan #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .digit_en   (digit_en),
    .dp         (dp),
    .code       (code),
    .num        (num),
    .an         (an),
    .seg        (seg),
    .dp_n       (dp_n),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs n cycles from IDLE with en already high; cycle k is sampled after the k-th edge.
  task automatic run_scan(input int n, input logic [7:0] den, input logic [7:0] dpv);
    logic [7:0] exp_an;
    logic [7:0] onehot;
    int p, d;
    for (int k = 1; k <= n; k++) begin
      tick();
      p = (k - 1) % PERIOD;
      d = ((k - 1) / PERIOD) % 8;
      onehot = 8'b0000_0001 << d;
      exp_an = (p >= BLANK_CYC && den[d]) ? ~onehot : 8'hFF;
      check("an", {24'd0, an}, {24'd0, exp_an});
      check("num", {29'd0, num}, d);
      check("frame_tick", {31'd0, frame_tick}, {31'd0, (p == 0 && d == 0 && k > 1)});
      if (p >= 1) begin
        check("seg", {25'd0, seg}, {25'd0, force_en ? HEX[force_val] : HEX[d]});
        check("dp_n", {31'd0, dp_n}, {31'd0, ~dpv[d]});
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    digit_en  = 8'hFF;
    dp        = 8'h00;
    force_en  = 1'b0;
    force_val = 4'h0;

    #1;
    check("rst_an", {24'd0, an}, 32'hFF);
    check("rst_seg", {25'd0, seg}, 32'h7F);
    check("rst_dp_n", {31'd0, dp_n}, 32'd1);
    check("rst_num", {29'd0, num}, 32'd0);
    check("rst_tick", {31'd0, frame_tick}, 32'd0);

    tick();
    rst = 1'b0;
    tick();
    check("idle_an", {24'd0, an}, 32'hFF);
    check("idle_num", {29'd0, num}, 32'd0);

    // Full scan, two frames, code follows num.
    en = 1'b1;
    run_scan(2 * 8 * PERIOD, 8'hFF, 8'h00);

    // Last cycle above is SHOW of digit 7: reset must act without a clock edge.
    #2 rst = 1'b1;
    #1;
    check("async_an", {24'd0, an}, 32'hFF);
    check("async_seg", {25'd0, seg}, 32'h7F);
    check("async_dp_n", {31'd0, dp_n}, 32'd1);
    check("async_num", {29'd0, num}, 32'd0);

    // Blanking of digit 2, resuming straight from reset release with en held high.
    digit_en = 8'b1111_1011;
    tick();
    rst = 1'b0;
    run_scan(8 * PERIOD, 8'b1111_1011, 8'h00);

    // Decimal point on digit 0 with a fixed code of F.
    en = 1'b0;
    tick();
    digit_en  = 8'hFF;
    dp        = 8'h01;
    force_en  = 1'b1;
    force_val = 4'hF;
    en        = 1'b1;
    run_scan(8 * PERIOD, 8'hFF, 8'h01);

    // Enable drop at SHOW cnt=1 of digit 5.
    en = 1'b0;
    tick();
    dp       = 8'h00;
    force_en = 1'b0;
    en       = 1'b1;
    run_scan(5 * PERIOD + BLANK_CYC + 2, 8'hFF, 8'h00);
    check("pre_drop_an", {24'd0, an}, 32'hDF);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("drop_an", {24'd0, an}, 32'hFF);
      check("drop_num", {29'd0, num}, 32'd0);
      check("drop_tick", {31'd0, frame_tick}, 32'd0);
    end
    en = 1'b1;
    run_scan(2 * PERIOD, 8'hFF, 8'h00);

    // Decode sweep in IDLE (num held at 0), one-cycle latency from code to seg.
    en = 1'b0;
    tick();
    force_en = 1'b1;
    for (int c = 0; c < 16; c++) begin
      force_val = c[3:0];
      #1;
      if (c > 0) check("sweep_hold", {25'd0, seg}, {25'd0, HEX[c-1]});
      tick();
      check("sweep_seg", {25'd0, seg}, {25'd0, HEX[c]});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Time-multiplexed driver for the board's eight-digit, common-anode seven-segment display. It cycles the digit number `num` out to the digit-select mux and takes back that digit's 4-bit hex `code`. It decodes `code` to active-low segments and drives one active-low anode at a time. A blanking gap at each digit switch suppresses ghosting. It sits between the display-data logic (digit mux) and the FPGA display pins.

## Interface
Parameters:
- `SCAN_DIV`, 100000, clock cycles each digit is lit (SHOW length); must be ≥ 2.
- `BLANK_CYC`, 1000, clock cycles all anodes are off between digits; must be ≥ 1 and < `SCAN_DIV`.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  scan enable; low forces the display dark.
- `digit_en`  in  8  per-digit enable; bit i low blanks digit i during its slot.
- `dp`  in  8  decimal point request per digit, active-high.
- `code`  in  4  hex value of digit `num`, returned combinationally from the digit mux.
- `num`  out  3  current digit number, 0–7, to the digit mux.
- `an`  out  8  anode selects, active-low, one-hot-low or all-high.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `dp_n`  out  1  decimal point, active-low.
- `frame_tick`  out  1  one-cycle pulse when `num` wraps from 7 to 0.

## Operation
- All outputs are registered.
- Reset values: `num`=0, `an`=8'hFF, `seg`=7'h7F, `dp_n`=1, `frame_tick`=0, state IDLE, counter 0.
- Counter `cnt` has width $clog2(SCAN_DIV). It is shared by BLANK and SHOW and clears on every state change.
- IDLE:
  - `an`=FF, `num`=0, `cnt`=0.
  - `en`=1 → BLANK.
- BLANK:
  - `an`=FF.
  - Counts 0..BLANK_CYC-1.
  - At BLANK_CYC-1 → SHOW.
- SHOW:
  - `an[num]`=0 if `digit_en[num]`, else `an`=FF.
  - Counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 → BLANK, with `num` ← `num`+1 (mod 8).
  - `frame_tick`=1 on that edge iff the old `num`=7.
- `en`=0 in any state → IDLE on the next edge. This aborts mid-slot and does not pulse `frame_tick`.
- Decode, every cycle in all states: `seg` ← hex_to_seg(`code`) and `dp_n` ← ~`dp[num]`. Only `an` gates visibility.
- Hex map (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110

## Timing
- Digit period = BLANK_CYC + SCAN_DIV cycles. Frame = 8 × period.
- `num` changes on the edge entering BLANK. `code` settles during BLANK. `seg` reflects the new digit at least BLANK_CYC−1 cycles before its anode turns on.
- `code` → `seg` latency: 1 cycle.
- `an` goes low on the edge entering SHOW and high on the edge leaving it. It is never low for two digits on the same cycle.
- `digit_en`/`dp` are sampled every cycle; a change mid-SHOW takes effect on the next edge.
- Reset asserted mid-operation: all outputs take their reset values immediately (asynchronous). After deassertion with `en`=1, operation resumes through IDLE→BLANK for digit 0.

## Structure
- The shared display package holds:
  - the segment patterns for hex 0–F, as `SEG_*` constants;
  - `SEG_OFF`=7'h7F;
  - `AN_OFF`=8'hFF;
  - the state encoding IDLE/BLANK/SHOW.
- Sub-module `hex_to_seg`: combinational 4-bit → 7-bit active-low decoder, instantiated once.

## Test plan
(SCAN_DIV=4, BLANK_CYC=2)
- **Reset.** Assert `rst` asynchronously mid-SHOW → `an`=FF, `seg`=7F, `dp_n`=1, `num`=0 on the same cycle, without waiting for a clock edge.
- **Full scan.**
  - Stimulus: `en`=1, `digit_en`=FF, mux returns `code`=`num`.
  - Required: `an` sequence FE,FD,…,7F. Each is low for 4 cycles, separated by 2 cycles of FF.
  - Required: `seg`=1000000 while `an`=FE, and 1111000 while `an`=7F.
  - Required: `frame_tick` pulses once per 48 cycles, on the 7→0 transition.
- **Blanking.** `digit_en`=8'b1111_1011 → during digit 2's slot `an`=FF for all 4 SHOW cycles; timing of the other digits is unchanged.
- **Decimal point.** `dp`=8'h01 → `dp_n`=0 only while `num`=0; `code`=F gives `seg`=0001110.
- **Enable drop.** `en`=0 at SHOW cnt=1 of digit 5 → next edge `an`=FF, `num`=0, no `frame_tick`. Re-enable → digit 0 lights after 2 BLANK cycles.
- **Decode sweep.** Hold `num`=0 slot, step `code` 0..F → `seg` matches the hex map, one cycle after each `code` change.
